memory_cycle: RTL and testbench

Memory stage of the five-stage pipelined MIPS core, the consumer of the execute stage's outputs. Registers the execute results in an EX/MEM pipeline register, performs data-memory loads and stores, resolves branches, and registers the write-back payload into a MEM/WB pipeline register. It also exports the M-stage destination and ALU result for the forwarding unit.

---
 rtl/memory_cycle_if.sv | 22 ++
 rtl/memory_cycle.sv | 81 ++++++++
 tb/tb_memory_cycle.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/memory_cycle_if.sv
// memory_cycle_if: execute-stage inputs, stall/flush controls and M/W-stage outputs of the memory stage.
interface memory_cycle_if;
    logic        StallM, FlushM;
    logic        RegWriteE, MemWriteE, MemReadE, MemToRegE, BranchE, JumpE, ZeroE;
    logic [31:0] ALUResE, WriteDataE, AddResultE;
    logic [4:0]  DesRegE;
    logic        PCSrcM, JumpM, RegWriteM, RegWriteW;
    logic [31:0] BranchTargetM, ALUResM, ResultW, ReadDataW, ALUResW;
    logic [4:0]  DesRegM, DesRegW;
    modport master (
        output StallM, FlushM, RegWriteE, MemWriteE, MemReadE, MemToRegE, BranchE, JumpE, ZeroE,
               ALUResE, WriteDataE, AddResultE, DesRegE,
        input  PCSrcM, JumpM, RegWriteM, RegWriteW, BranchTargetM, ALUResM, ResultW, ReadDataW,
               ALUResW, DesRegM, DesRegW
    );
    modport slave (
        input  StallM, FlushM, RegWriteE, MemWriteE, MemReadE, MemToRegE, BranchE, JumpE, ZeroE,
               ALUResE, WriteDataE, AddResultE, DesRegE,
        output PCSrcM, JumpM, RegWriteM, RegWriteW, BranchTargetM, ALUResM, ResultW, ReadDataW,
               ALUResW, DesRegM, DesRegW
    );
endinterface

// File: rtl/memory_cycle.sv
// memory_cycle: MIPS memory stage - EX/MEM register, word data memory, branch resolve, MEM/WB register.
module memory_cycle #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input logic          clk,
    input logic          rst,
    memory_cycle_if.slave bus
);
    logic          reg_write_m, mem_write_m, mem_to_reg_m, branch_m, jump_m, zero_m;
    logic [31:0]   alu_res_m, write_data_m, add_result_m;
    logic [4:0]    des_reg_m;
    logic          reg_write_w, mem_to_reg_w;
    logic [31:0]   read_data_w, alu_res_w;
    logic [4:0]    des_reg_w;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic [31:0]   rd;

    always_ff @(posedge clk) begin
        if (rst || bus.FlushM) begin
            reg_write_m  <= 1'b0;
            mem_write_m  <= 1'b0;
            mem_to_reg_m <= 1'b0;
            branch_m     <= 1'b0;
            jump_m       <= 1'b0;
            zero_m       <= 1'b0;
            alu_res_m    <= '0;
            write_data_m <= '0;
            add_result_m <= '0;
            des_reg_m    <= '0;
        end else if (!bus.StallM) begin
            reg_write_m  <= bus.RegWriteE;
            mem_write_m  <= bus.MemWriteE;
            mem_to_reg_m <= bus.MemToRegE;
            branch_m     <= bus.BranchE;
            jump_m       <= bus.JumpE;
            zero_m       <= bus.ZeroE;
            alu_res_m    <= bus.ALUResE;
            write_data_m <= bus.WriteDataE;
            add_result_m <= bus.AddResultE;
            des_reg_m    <= bus.DesRegE;
        end
    end

    // Word index only; byte-offset and high address bits wrap.
    assign idx = alu_res_m[AW+1:2];
    assign rd  = mem[idx];

    always_ff @(posedge clk)
        if (mem_write_m && !bus.StallM && !rst) mem[idx] <= write_data_m;

    // A stall leaves M holding its instruction, so W receives a bubble.
    always_ff @(posedge clk) begin
        if (rst || bus.StallM) begin
            reg_write_w  <= 1'b0;
            mem_to_reg_w <= 1'b0;
            read_data_w  <= '0;
            alu_res_w    <= '0;
            des_reg_w    <= '0;
        end else begin
            reg_write_w  <= reg_write_m;
            mem_to_reg_w <= mem_to_reg_m;
            read_data_w  <= rd;
            alu_res_w    <= alu_res_m;
            des_reg_w    <= des_reg_m;
        end
    end

    assign bus.PCSrcM        = branch_m & zero_m;
    assign bus.BranchTargetM = add_result_m;
    assign bus.JumpM         = jump_m;
    assign bus.RegWriteM     = reg_write_m;
    assign bus.DesRegM       = des_reg_m;
    assign bus.ALUResM       = alu_res_m;
    assign bus.RegWriteW     = reg_write_w;
    assign bus.DesRegW       = des_reg_w;
    assign bus.ReadDataW     = read_data_w;
    assign bus.ALUResW       = alu_res_w;
    assign bus.ResultW       = mem_to_reg_w ? read_data_w : alu_res_w;
endmodule

// File: tb/tb_memory_cycle.sv
// tb_memory_cycle: vector table with a W-stage scoreboard, plus hand sequences for stall, flush and reset.
module tb_memory_cycle;
    logic clk, rst;
    memory_cycle_if bus ();
    memory_cycle #(.DEPTH(64), .AW(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        logic        rw, mw, mr, mtr, br, z, j;
        logic [31:0] alu, wd, add;
        logic [4:0]  des;
        logic        e_pc;
        logic        e_rw;
        logic [4:0]  e_des;
        logic [31:0] e_res;
    } vec_t;
    typedef struct {
        logic        rw;
        logic [4:0]  des;
        logic [31:0] res;
    } wexp_t;

    vec_t  tbl [11];
    wexp_t q [$];
    wexp_t w;
    int    pass_cnt = 0;
    int    total_cnt = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t v(logic rw, mw, mr, mtr, br, z, j, logic [31:0] alu, wd, add,
                               logic [4:0] des, logic e_pc, e_rw, logic [4:0] e_des, logic [31:0] e_res);
        vec_t x;
        x.rw = rw; x.mw = mw; x.mr = mr; x.mtr = mtr; x.br = br; x.z = z; x.j = j;
        x.alu = alu; x.wd = wd; x.add = add; x.des = des;
        x.e_pc = e_pc; x.e_rw = e_rw; x.e_des = e_des; x.e_res = e_res;
        return x;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        total_cnt++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", n, act, exp);
        else pass_cnt++;
    endtask

    task automatic drive(vec_t x);
        bus.RegWriteE = x.rw; bus.MemWriteE = x.mw; bus.MemReadE = x.mr; bus.MemToRegE = x.mtr;
        bus.BranchE = x.br; bus.ZeroE = x.z; bus.JumpE = x.j;
        bus.ALUResE = x.alu; bus.WriteDataE = x.wd; bus.AddResultE = x.add; bus.DesRegE = x.des;
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic nop();
        drive(v(0,0,0,0,0,0,0, 0,0,0, 0, 0,0,0,0));
    endtask

    initial begin
        //           rw mw mr mtr br z j  alu          wd            add    des  pc rwW desW res
        tbl[0]  = v(1, 0, 0, 0,  0, 0, 0, 32'h4,       32'h0,        32'h0,  8,  0, 1,  8, 32'h4);
        tbl[1]  = v(0, 1, 0, 0,  0, 0, 0, 32'h1C,      32'hABCDEF,   32'h0,  0,  0, 0,  0, 32'h1C);
        tbl[2]  = v(1, 0, 1, 1,  0, 0, 0, 32'h1C,      32'h0,        32'h0,  9,  0, 1,  9, 32'hABCDEF);
        tbl[3]  = v(1, 0, 1, 1,  0, 0, 0, 32'h11C,     32'h0,        32'h0, 10,  0, 1, 10, 32'hABCDEF);
        tbl[4]  = v(0, 0, 0, 0,  1, 1, 0, 32'h0,       32'h0,        32'h40, 0,  1, 0,  0, 32'h0);
        tbl[5]  = v(0, 0, 0, 0,  1, 0, 0, 32'h0,       32'h0,        32'h80, 0,  0, 0,  0, 32'h0);
        tbl[6]  = v(0, 0, 0, 0,  0, 0, 1, 32'h0,       32'h0,        32'h0,  0,  0, 0,  0, 32'h0);
        tbl[7]  = v(0, 1, 0, 0,  0, 0, 0, 32'h24,      32'h1111,     32'h0,  0,  0, 0,  0, 32'h24);
        tbl[8]  = v(1, 1, 1, 1,  0, 0, 0, 32'h24,      32'h2222,     32'h0,  4,  0, 1,  4, 32'h1111);
        tbl[9]  = v(1, 0, 1, 1,  0, 0, 0, 32'h24,      32'h0,        32'h0,  5,  0, 1,  5, 32'h2222);
        tbl[10] = v(1, 0, 1, 1,  0, 0, 0, 32'h1F,      32'h0,        32'h0,  6,  0, 1,  6, 32'hABCDEF);

        rst = 1; bus.StallM = 0; bus.FlushM = 0;
        nop();
        step();
        chk("reset PCSrcM", {31'b0, bus.PCSrcM}, 0);
        chk("reset RegWriteW", {31'b0, bus.RegWriteW}, 0);
        chk("reset ResultW", bus.ResultW, 0);
        chk("reset ALUResM", bus.ALUResM, 0);
        rst = 0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i]);
            w.rw = tbl[i].e_rw; w.des = tbl[i].e_des; w.res = tbl[i].e_res;
            q.push_back(w);
            step();
            chk($sformatf("v%0d PCSrcM", i), {31'b0, bus.PCSrcM}, {31'b0, tbl[i].e_pc});
            chk($sformatf("v%0d JumpM", i), {31'b0, bus.JumpM}, {31'b0, tbl[i].j});
            chk($sformatf("v%0d BranchTargetM", i), bus.BranchTargetM, tbl[i].add);
            chk($sformatf("v%0d ALUResM", i), bus.ALUResM, tbl[i].alu);
            if (q.size() > 1) begin
                w = q.pop_front();
                chk("W RegWriteW", {31'b0, bus.RegWriteW}, {31'b0, w.rw});
                chk("W DesRegW", {27'b0, bus.DesRegW}, {27'b0, w.des});
                chk("W ResultW", bus.ResultW, w.res);
            end
        end
        nop();
        step();
        w = q.pop_front();
        chk("W last RegWriteW", {31'b0, bus.RegWriteW}, {31'b0, w.rw});
        chk("W last DesRegW", {27'b0, bus.DesRegW}, {27'b0, w.des});
        chk("W last ResultW", bus.ResultW, w.res);
        q.delete();

        // stall: store 0x55 held in M for two edges
        drive(v(0,1,0,0,0,0,0, 32'h8, 32'h33, 0, 0, 0,0,0,0)); step();
        drive(v(1,0,0,0,0,0,0, 32'h70, 0, 0, 7, 0,0,0,0)); step();
        drive(v(0,1,0,0,0,0,0, 32'h8, 32'h55, 0, 0, 0,0,0,0)); step();
        chk("pre-stall RegWriteW", {31'b0, bus.RegWriteW}, 1);
        chk("pre-stall DesRegW", {27'b0, bus.DesRegW}, 7);
        chk("pre-stall mem", dut.mem[2], 32'h33);
        nop();
        bus.StallM = 1;
        for (int k = 0; k < 2; k++) begin
            step();
            chk($sformatf("stall%0d mem", k), dut.mem[2], 32'h33);
            chk($sformatf("stall%0d RegWriteW", k), {31'b0, bus.RegWriteW}, 0);
            chk($sformatf("stall%0d ALUResM", k), bus.ALUResM, 32'h8);
        end
        bus.StallM = 0;
        step();
        chk("release mem", dut.mem[2], 32'h55);
        chk("release ResultW", bus.ResultW, 32'h8);
        chk("release ALUResM", bus.ALUResM, 0);
        drive(v(1,0,1,1,0,0,0, 32'h8, 0, 0, 11, 0,0,0,0)); step();
        nop(); step();
        chk("stall load ResultW", bus.ResultW, 32'h55);
        chk("stall load DesRegW", {27'b0, bus.DesRegW}, 11);

        // flush wins over stall
        drive(v(1,1,0,0,0,0,0, 32'h8, 32'h77, 0, 12, 0,0,0,0));
        bus.FlushM = 1; bus.StallM = 1;
        step();
        chk("flush RegWriteM", {31'b0, bus.RegWriteM}, 0);
        chk("flush ALUResM", bus.ALUResM, 0);
        bus.FlushM = 0; bus.StallM = 0;
        nop(); step();
        chk("flush RegWriteW", {31'b0, bus.RegWriteW}, 0);
        chk("flush mem", dut.mem[2], 32'h55);

        // reset with a store pending in M
        drive(v(0,1,0,0,1,1,1, 32'h8, 32'h99, 32'h44, 0, 0,0,0,0)); step();
        nop(); rst = 1; step();
        chk("rst mem kept", dut.mem[2], 32'h55);
        chk("rst PCSrcM", {31'b0, bus.PCSrcM}, 0);
        chk("rst JumpM", {31'b0, bus.JumpM}, 0);
        chk("rst BranchTargetM", bus.BranchTargetM, 0);
        chk("rst ALUResM", bus.ALUResM, 0);
        chk("rst ResultW", bus.ResultW, 0);
        chk("rst ALUResW", bus.ALUResW, 0);
        rst = 0;
        drive(v(1,0,1,1,0,0,0, 32'h1C, 0, 0, 13, 0,0,0,0)); step();
        nop(); step();
        chk("post-rst load ResultW", bus.ResultW, 32'hABCDEF);
        chk("post-rst load DesRegW", {27'b0, bus.DesRegW}, 13);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
